// File: rtl/seg7_pkg.sv
// Shared 7-segment encodings and the hex-to-segment lookup.
// Segment bit order is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;

  // Nibble to segment pattern: 0-9 then A,b,C,d,E,F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble -> active-high segment pattern.
// Ports: nibble (4-bit hex digit in), seg_c (7-bit {g..a} pattern out).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_value/in_dp accept a
// new display value; blank_lz enables leading-zero blanking; enable freezes the
// scan and blanks the outputs; segments/dp/digit_sel drive the display pins;
// frame_done pulses when the scan wraps back to digit 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  // Inactive levels double as the XOR masks that apply output polarity.
  localparam logic [6:0]            SEG_INACT = {7{COMMON_ANODE}};
  localparam logic                  DP_INACT  = COMMON_ANODE;
  localparam logic [NUM_DIGITS-1:0] SEL_INACT = {NUM_DIGITS{COMMON_ANODE}};

  logic [PRE_W-1:0]      presc_q;
  logic [IDX_W-1:0]      idx_q;
  logic [VAL_W-1:0]      pend_value_q;
  logic [NUM_DIGITS-1:0] pend_dp_q;
  logic [VAL_W-1:0]      disp_value_q;
  logic [NUM_DIGITS-1:0] disp_dp_q;

  logic                  tc;
  logic                  wrap;
  logic                  accept;
  logic                  commit;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_above;
  logic [6:0]            seg_dec;

  // Scan timing and handshake qualifiers. in_ready low means a value is pending.
  assign tc     = enable && (presc_q == PRE_LAST);
  assign wrap   = tc && (idx_q == IDX_LAST);
  assign accept = in_valid && in_ready;
  assign commit = !in_ready && (wrap || !enable);

  // Leading-zero mask: digit k>0 blanks when it and every higher nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above    = zero_above && (disp_value_q[4*k +: 4] == 4'h0);
      blank_mask[k] = blank_lz && zero_above;
    end
  end

  // Select the nibble, dp bit, blank flag and one-hot enable of the current digit.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    blank  = 1'b0;
    sel    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib    = disp_value_q[4*k +: 4];
        dp_bit = disp_dp_q[k];
        blank  = blank_mask[k];
        sel[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (nib),
    .seg_c  (seg_dec)
  );

  // Prescaler and digit index; both hold while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (enable) begin
      if (tc) begin
        presc_q <= '0;
        idx_q   <= wrap ? '0 : idx_q + IDX_W'(1);
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

  // One-entry pending buffer; display only changes at a wrap or while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      in_ready     <= 1'b1;
    end else if (accept) begin
      pend_value_q <= in_value;
      pend_dp_q    <= in_dp;
      in_ready     <= 1'b0;
    end else if (commit) begin
      disp_value_q <= pend_value_q;
      disp_dp_q    <= pend_dp_q;
      in_ready     <= 1'b1;
    end
  end

  // Output pins, polarity applied before the flop so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments   <= SEG_INACT;
      dp         <= DP_INACT;
      digit_sel  <= SEL_INACT;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (enable) begin
        segments  <= (blank ? SEG_OFF : seg_dec) ^ SEG_INACT;
        dp        <= dp_bit ^ DP_INACT;
        digit_sel <= sel ^ SEL_INACT;
      end else begin
        segments  <= SEG_INACT;
        dp        <= DP_INACT;
        digit_sel <= SEL_INACT;
      end
    end
  end

endmodule
